// File: rtl/uart_tx_ctl_if.sv
//==============================================================================
// Module      : uart_tx_ctl_if
// Description : Byte-write strobe and line/status bundle of the UART transmitter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface uart_tx_ctl_if;
    logic       uart_we;
    logic [7:0] uart;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overflow;

    modport master (
        output uart_we, uart,
        input  tx, busy, fifo_full, fifo_empty, overflow
    );

    modport slave (
        input  uart_we, uart,
        output tx, busy, fifo_full, fifo_empty, overflow
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_ctl.sv
//==============================================================================
// Module      : uart_tx_ctl
// Description : FIFO-buffered 8N1 UART transmitter, LSB first.
//               Define UART_TX_PARITY_EN for 8E1 frames (even parity bit).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_tx_ctl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  wire logic     clk,
    input  wire logic     rst,
    uart_tx_ctl_if.slave  bus
);

    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_FULL  = c_CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  w_count_nxt;
    logic                r_full;
    logic                r_empty;
    logic                r_overflow;
    logic                r_busy;

    state_t              r_state;
    logic                r_tx;
    logic [c_BAUD_W-1:0] r_baud_cnt;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
`ifdef UART_TX_PARITY_EN
    logic                r_parity;
`endif

    logic                w_bit_end;
    logic                w_slot;
    logic                w_pop;
    logic                w_idle_nxt;
    logic                w_push;
    logic [7:0]          w_head;

    // A pop can only happen in IDLE or on the final cycle of a stop bit.
    assign w_bit_end  = (r_baud_cnt == c_BAUD_LAST);
    assign w_slot     = (r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end);
    assign w_pop      = w_slot && !r_empty;
    assign w_idle_nxt = w_slot && r_empty;
    assign w_push     = bus.uart_we && (!r_full || w_pop);
    assign w_head     = r_mem[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.uart;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (bus.uart_we && !w_push) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_CNT_FULL);
            r_empty <= (w_count_nxt == '0);
            r_busy  <= (w_count_nxt != '0) || !w_idle_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            if ((r_state == S_IDLE) || w_bit_end) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + c_BAUD_W'(1);
            end

            if (w_pop) begin
                r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
                r_parity <= ^w_head;
`endif
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state   <= S_DATA;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    // Back-to-back frames go straight to START with no idle bit.
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_state <= S_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx         = r_tx;
    assign bus.busy       = r_busy;
    assign bus.fifo_full  = r_full;
    assign bus.fifo_empty = r_empty;
    assign bus.overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctl.sv
//==============================================================================
// Module      : tb_uart_tx_ctl
// Description : Self-checking bench for uart_tx_ctl (UART_TX_PARITY_EN aware).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_tx_ctl;

    localparam int C = 4;
    localparam int D = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_ctl_if u_if ();

    uart_tx_ctl #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: queue of buffered bytes plus the schedule of the frame on the line.
    logic [7:0] m_q [$];
    logic [7:0] m_sent [$];
    logic [7:0] dec_q [$];
    logic [7:0] exp_q [$];
    int         m_fs    = -1000;
    int         m_end   = -1;
    logic [7:0] m_byte  = 8'h00;
    logic       m_ovf   = 1'b0;
    bit         m_valid = 1'b0;
    bit         d_act   = 1'b0;
    int         d_t     = 0;
    logic [7:0] d_byte  = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_tx(input int c);
        int k;
        if (c < m_fs || c > m_end) return 1'b1;
        k = (c - m_fs) / C;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^m_byte;
`endif
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        bit pop;
        bit acc;
        int k;
        if (m_valid) begin
            chk("tx",         u_if.tx,         exp_tx(cyc));
            chk("busy",       u_if.busy,       (m_q.size() != 0) || (cyc <= m_end));
            chk("fifo_full",  u_if.fifo_full,  m_q.size() == D);
            chk("fifo_empty", u_if.fifo_empty, m_q.size() == 0);
            chk("overflow",   u_if.overflow,   m_ovf);
            // Line decoder sampling mid-bit.
            if (!d_act) begin
                if (u_if.tx === 1'b0) begin
                    d_act = 1'b1;
                    d_t   = 0;
                end
            end else begin
                d_t++;
                if (d_t % C == C / 2) begin
                    k = d_t / C;
                    if (k >= 1 && k <= 8) d_byte[k-1] = u_if.tx;
                    if (k == FB - 1) begin
                        dec_q.push_back(d_byte);
                        d_act = 1'b0;
                    end
                end
            end
        end
        if (rst) begin
            m_q.delete();
            m_sent.delete();
            dec_q.delete();
            m_fs    = -1000;
            m_end   = -1;
            m_ovf   = 1'b0;
            m_valid = 1'b1;
            d_act   = 1'b0;
        end else if (m_valid) begin
            pop = (m_q.size() > 0) && (cyc >= m_end);
            acc = u_if.uart_we && ((m_q.size() < D) || pop);
            if (pop) begin
                m_byte = m_q.pop_front();
                m_sent.push_back(m_byte);
                m_fs  = cyc + 1;
                m_end = cyc + FB * C;
            end
            if (acc) m_q.push_back(u_if.uart);
            if (u_if.uart_we && !acc) m_ovf = 1'b1;
        end
        cyc++;
    end

    task automatic write_byte(input logic [7:0] b);
        u_if.uart_we = 1'b1;
        u_if.uart    = b;
        @(posedge clk); #1;
        u_if.uart_we = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (u_if.busy !== 1'b0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_idle"}, u_if.busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_cycle(input string tag, input int target);
        int n = 0;
        while (cyc < target && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_reach"}, cyc, target);
    endtask

    task automatic check_dec(input string tag);
        chk({tag, "_count"}, dec_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < dec_q.size(); i++) begin
            chk({tag, "_byte"}, dec_q[i], exp_q[i]);
        end
        dec_q.delete();
        m_sent.delete();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.uart_we = 1'b0;
        u_if.uart    = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_tx",    u_if.tx,         1'b1);
        chk("rst_busy",  u_if.busy,       1'b0);
        chk("rst_empty", u_if.fifo_empty, 1'b1);
        chk("rst_full",  u_if.fifo_full,  1'b0);
        chk("rst_ovf",   u_if.overflow,   1'b0);

        // Single byte, start-bit latency.
        write_byte(8'h55);
        chk("lat_n1_tx", u_if.tx, 1'b1);
        @(posedge clk); #1;
        chk("lat_n2_tx", u_if.tx, 1'b0);
        wait_idle("single");
        exp_q = {8'h55};
        check_dec("single");

        // Back-to-back frames.
        write_byte(8'hA5);
        write_byte(8'h3C);
        wait_idle("b2b");
        exp_q = {8'hA5, 8'h3C};
        check_dec("b2b");

        // Overflow.
        for (int i = 1; i <= 6; i++) write_byte(8'(i));
        chk("ovf_set",  u_if.overflow,  1'b1);
        chk("ovf_full", u_if.fifo_full, 1'b1);
        wait_idle("ovf");
        exp_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        check_dec("ovf");
        chk("ovf_sticky", u_if.overflow, 1'b1);
        pulse_reset();
        chk("ovf_cleared", u_if.overflow, 1'b0);

        // Full FIFO with a pop in the same cycle.
        for (int i = 1; i <= 5; i++) write_byte(8'(i));
        chk("fp_full", u_if.fifo_full, 1'b1);
        wait_cycle("fp", m_end);
        write_byte(8'hEE);
        chk("fp_ovf",  u_if.overflow,  1'b0);
        chk("fp_full2", u_if.fifo_full, 1'b1);
        wait_idle("fp");
        exp_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hEE};
        check_dec("fp");
        chk("fp_ovf_end", u_if.overflow, 1'b0);

        // Reset during data bit 3.
        write_byte(8'hFF);
        write_byte(8'h12);
        wait_cycle("mid", m_fs + 4 * C + 1);
        pulse_reset();
        chk("mid_tx",    u_if.tx,         1'b1);
        chk("mid_busy",  u_if.busy,       1'b0);
        chk("mid_empty", u_if.fifo_empty, 1'b1);
        repeat (3 * FB * C) @(posedge clk);
        #1;
        exp_q.delete();
        check_dec("mid");

`ifdef UART_TX_PARITY_EN
        write_byte(8'h07);
        write_byte(8'h03);
        wait_idle("par");
        exp_q = {8'h07, 8'h03};
        check_dec("par");
`endif

        // Randomised traffic against the model.
        pulse_reset();
        for (int i = 0; i < 600; i++) begin
            u_if.uart_we = ($urandom_range(0, 5) == 0);
            u_if.uart    = 8'($urandom);
            @(posedge clk); #1;
        end
        u_if.uart_we = 1'b0;
        wait_idle("rand");
        exp_q = m_sent;
        check_dec("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
